// File: rtl/spi_master_cfg_pkg.sv
// Shared definitions for the configurable SPI master: FSM state encoding and
// mode constants ({cpol, cpha}) used by the master, future slave and benches.
package spi_master_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StXfer  = 2'd2,
        StHold  = 2'd3
    } spi_state_e;

    localparam logic [1:0] SpiMode0 = 2'b00;
    localparam logic [1:0] SpiMode1 = 2'b01;
    localparam logic [1:0] SpiMode2 = 2'b10;
    localparam logic [1:0] SpiMode3 = 2'b11;

endpackage

// File: rtl/spi_master_cfg_clk_gen.sv
// SCLK timing generator: a divider ticks once every H clk cycles while enabled and
// classifies ticks into leading/trailing SCLK edge strobes when edges are allowed.
module spi_master_cfg_clk_gen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             en_i,
    input  logic             edge_en_i,
    output logic             tick_o,
    output logic             lead_stb_o,
    output logic             trail_stb_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] reload_q;
    logic [DIV_W-1:0] reload_d;
    logic             phase_q;

    // clk_div=0 behaves like clk_div=1: reload value is H-1
    assign reload_d    = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    assign tick_o      = en_i && (cnt_q == '0);
    assign lead_stb_o  = tick_o && edge_en_i && !phase_q;
    assign trail_stb_o = tick_o && edge_en_i && phase_q;

    // Divider counter and leading/trailing phase tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            reload_q <= '0;
            phase_q  <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= reload_d;
            reload_q <= reload_d;
            phase_q  <= 1'b0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == '0) ? reload_q : cnt_q - DIV_W'(1);
            if (lead_stb_o || trail_stb_o) begin
                phase_q <= ~phase_q;
            end
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: runtime mode, bit order and divider, one-hot selects,
// start/busy/done handshake. Holds the FSM, shift registers and select decode.
module spi_master_cfg
    import spi_master_cfg_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_SS = 1,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_idx,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int unsigned EC_W = $clog2(2 * DATA_W) + 1;

    spi_state_e        state_q;
    logic              cpol_q, cpha_q, lsb_q;
    logic [DATA_W-1:0] tx_q, rx_sh_q, rx_q;
    logic [EC_W-1:0]   edge_cnt_q;
    logic              sclk_q, mosi_q, busy_q, done_q;
    logic [NUM_SS-1:0] ss_n_q;

    logic accept, edge_en, last_edge, tick, lead_stb, trail_stb;
    logic first_bit, next_bit;

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d,
                                                    input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] r,
                                                   input logic lsb, input logic b);
        return lsb ? {b, r[DATA_W-1:1]} : {r[DATA_W-2:0], b};
    endfunction

    assign accept    = start && (state_q == StIdle) && (32'(ss_idx) < NUM_SS);
    assign edge_en   = (state_q == StSetup) ||
                       ((state_q == StXfer) && (edge_cnt_q < EC_W'(2 * DATA_W)));
    assign last_edge = (edge_cnt_q == EC_W'(2 * DATA_W - 1));
    assign first_bit = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
    assign next_bit  = lsb_q ? tx_q[0] : tx_q[DATA_W-1];

    spi_master_cfg_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .div_i       (clk_div),
        .en_i        (state_q != StIdle),
        .edge_en_i   (edge_en),
        .tick_o      (tick),
        .lead_stb_o  (lead_stb),
        .trail_stb_o (trail_stb)
    );

    // Frame FSM with registered SPI pins, handshake and shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_q       <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    sclk_q <= cpol;
                    mosi_q <= 1'b0;
                    if (accept) begin
                        state_q    <= StSetup;
                        busy_q     <= 1'b1;
                        cpol_q     <= cpol;
                        cpha_q     <= cpha;
                        lsb_q      <= lsb_first;
                        ss_n_q     <= ~(NUM_SS'(1) << ss_idx);
                        edge_cnt_q <= '0;
                        rx_sh_q    <= '0;
                        // cpha=0 presents the first bit before the first edge
                        if (cpha) begin
                            tx_q <= tx_data;
                        end else begin
                            mosi_q <= first_bit;
                            tx_q   <= shift_out(tx_data, lsb_first);
                        end
                    end
                end
                StSetup, StXfer: begin
                    if (lead_stb || trail_stb) begin
                        sclk_q     <= ~sclk_q;
                        edge_cnt_q <= edge_cnt_q + EC_W'(1);
                        state_q    <= StXfer;
                    end
                    if (lead_stb) begin
                        if (!cpha_q) begin
                            rx_sh_q <= shift_in(rx_sh_q, lsb_q, miso);
                        end else begin
                            mosi_q <= next_bit;
                            tx_q   <= shift_out(tx_q, lsb_q);
                        end
                    end
                    if (trail_stb) begin
                        if (cpha_q) begin
                            rx_sh_q <= shift_in(rx_sh_q, lsb_q, miso);
                        end else if (!last_edge) begin
                            mosi_q <= next_bit;
                            tx_q   <= shift_out(tx_q, lsb_q);
                        end
                    end
                    // All edges issued: the next tick closes the final half period
                    if (tick && !edge_en) begin
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (tick) begin
                        state_q <= StIdle;
                        ss_n_q  <= '1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rx_q    <= rx_sh_q;
                        sclk_q  <= cpol_q;
                    end
                end
            endcase
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss_n    = ss_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: behavioural SPI slave plus a scoreboard of expected
// frame results checked whenever the master signals done.
module tb_spi_master_cfg;
    import spi_master_cfg_pkg::*;

    localparam int DW  = 8;
    localparam int NSS = 3;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic [7:0] tx_data = '0, clk_div = 8'd1;
    logic [1:0] ss_idx = '0;
    logic       miso;
    logic       sclk, mosi, busy, done;
    logic [2:0] ss_n;
    logic [7:0] rx_data;

    spi_master_cfg #(
        .DATA_W (DW),
        .NUM_SS (NSS),
        .DIV_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tx_data   (tx_data),
        .ss_idx    (ss_idx),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .clk_div   (clk_div),
        .miso      (miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss_n      (ss_n),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- slave model ----------------
    logic [7:0] s_tx = '0, s_rx = '0;
    logic       s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0, loopback = 1'b0;
    logic       s_miso = 1'b0, prev_sclk = 1'b0, prev_act = 1'b0, act, lead;
    int         s_k = 0, s_edges = 0;

    assign miso = loopback ? mosi : s_miso;

    function automatic logic s_bit(input logic [7:0] d, input logic lsb, input int k);
        if (k > 7) return 1'b0;
        return lsb ? d[k] : d[7-k];
    endfunction

    always @(posedge clk) begin
        #1;
        act = (ss_n != 3'b111);
        if (act && !prev_act) begin
            s_k = 0; s_rx = '0; s_edges = 0;
            if (!s_cpha) begin
                s_miso = s_bit(s_tx, s_lsb, 0);
                s_k = 1;
            end
        end
        if (act && (sclk != prev_sclk)) begin
            s_edges++;
            lead = (sclk != s_cpol);
            if (lead == !s_cpha) begin
                s_rx = s_lsb ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
            end else begin
                s_miso = s_bit(s_tx, s_lsb, s_k);
                s_k++;
            end
        end
        prev_act  = act;
        prev_sclk = sclk;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         lat;
        int         acc;
        logic       cpol;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_done = 0, n_pushed = 0;

    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e_mon = sb.pop_front();
                chk("rx_data", rx_data, e_mon.rx);
                chk("mosi_word", s_rx, e_mon.tx);
                chk("latency", cyc - e_mon.acc, e_mon.lat);
                chk("sclk_edges", s_edges, 2 * DW);
                chk("ss_release", ss_n, 3'b111);
                chk("busy_fall", busy, 0);
                chk("sclk_done", sclk, e_mon.cpol);
                n_done++;
            end
        end
    end

    task automatic push_exp(input logic [7:0] rx, input logic [7:0] tx, input int lat,
                            input int acc, input logic pol);
        exp_t e;
        e.rx = rx; e.tx = tx; e.lat = lat; e.acc = acc; e.cpol = pol;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic start_frame(input logic [7:0] tx, input logic [7:0] sdat,
                               input logic [1:0] mode, input logic lsb,
                               input logic [7:0] div, input logic [1:0] idx,
                               input logic lb);
        logic [2:0] ss_exp;
        int h;
        @(negedge clk);
        cpol = mode[1]; cpha = mode[0]; lsb_first = lsb; clk_div = div;
        ss_idx = idx; tx_data = tx;
        s_tx = sdat; s_cpol = mode[1]; s_cpha = mode[0]; s_lsb = lsb; loopback = lb;
        @(negedge clk);
        chk("idle_sclk", sclk, mode[1]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        h = (div == 0) ? 1 : int'(div);
        push_exp(lb ? tx : sdat, tx, (2 * DW + 2) * h, cyc, mode[1]);
        ss_exp = 3'b001;
        ss_exp = ~(ss_exp << idx);
        chk("busy_rise", busy, 1);
        chk("ss_select", ss_n, ss_exp);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_frame(input logic [7:0] tx, input logic [7:0] sdat,
                             input logic [1:0] mode, input logic lsb,
                             input logic [7:0] div, input logic [1:0] idx,
                             input logic lb);
        start_frame(tx, sdat, mode, lsb, div, idx, lb);
        wait_done(1000);
    endtask

    initial begin
        int acc_a, n;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ss_n", ss_n, 3'b111);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx_data, 0);
        rst_n = 1'b1;

        // Mode 0, H=2, MSB first
        run_frame(8'hAB, 8'h61, SpiMode0, 1'b0, 8'd2, 2'd0, 1'b0);
        // Mode 3, LSB first, H=1
        run_frame(8'h45, 8'hC3, SpiMode3, 1'b1, 8'd1, 2'd0, 1'b0);
        // Modes 1 and 2 in loopback
        run_frame(8'h5A, 8'h00, SpiMode1, 1'b0, 8'd3, 2'd0, 1'b1);
        run_frame(8'h5A, 8'h00, SpiMode2, 1'b0, 8'd1, 2'd0, 1'b1);
        run_frame(8'h5A, 8'h00, SpiMode2, 1'b1, 8'd2, 2'd0, 1'b1);

        // Mid-frame start and config changes ignored; start held into done cycle
        start_frame(8'hA5, 8'h61, SpiMode0, 1'b0, 8'd2, 2'd0, 1'b0);
        acc_a = sb[sb.size()-1].acc;
        repeat (10) @(negedge clk);
        tx_data = 8'hFF; cpol = 1'b1; lsb_first = 1'b1; clk_div = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        tx_data = 8'h3C; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd2;
        start = 1'b1;
        push_exp(8'h61, 8'h3C, (2 * DW + 2) * 2, acc_a + (2 * DW + 2) * 2 + 1, 1'b0);
        wait_done(1000);
        chk("b2b_gap_busy", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_ss", ss_n, 3'b110);
        wait_done(1000);

        // Reset mid-frame
        start_frame(8'h77, 8'h18, SpiMode0, 1'b0, 8'd2, 2'd0, 1'b0);
        n = 0;
        while (s_edges < 5 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("edges_before_rst", (s_edges >= 5) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_mosi", mosi, 0);
        chk("mid_rst_ss_n", ss_n, 3'b111);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rx", rx_data, 0);
        n_pushed = n_pushed - sb.size();
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_frame(8'h96, 8'h2D, SpiMode0, 1'b0, 8'd2, 2'd0, 1'b0);

        // Slave select decode and rejection
        run_frame(8'hC6, 8'h39, SpiMode0, 1'b0, 8'd1, 2'd2, 1'b0);
        @(negedge clk);
        ss_idx = 2'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("reject_busy", busy, 0);
        chk("reject_ss", ss_n, 3'b111);
        repeat (3) @(posedge clk);
        #1;
        chk("reject_busy_later", busy, 0);

        // clk_div=0 behaves as clk_div=1
        run_frame(8'h3E, 8'hB1, SpiMode1, 1'b1, 8'd0, 2'd1, 1'b0);
        run_frame(8'h3E, 8'hB1, SpiMode1, 1'b1, 8'd1, 2'd1, 1'b0);

        repeat (4) @(posedge clk);
        #2;
        chk("done_count", n_done, n_pushed);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
